weight_loader: RTL and testbench

Configuration master for the NPU neuron array. It accepts a host word stream over a valid/ready handshake and parses it into per-neuron blocks: a header, then one bias, then N weights. It drives the shared weight/bias configuration bus that every Neuron instance snoops and filters on its layer and neuron number. It sits between the host/DMA interface and the layer array, and is the writer side of the Neuron weight-load port.

---
 rtl/npu_cfg_pkg.sv | 25 ++
 rtl/weight_loader.sv | 145 ++++++++++++++
 tb/tb_weight_loader.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_cfg_pkg.sv
// Shared definitions for the NPU configuration path: loader FSM states and
// the bit positions of the fields inside a neuron-block header word.
package npu_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        BIAS = 3'd2,
        WGT  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int unsigned LAYER_MSB   = 31;
    localparam int unsigned LAYER_LSB   = 24;
    localparam int unsigned NEURON_MSB  = 23;
    localparam int unsigned NEURON_LSB  = 16;
    localparam int unsigned COUNT_MSB   = 15;
    localparam int unsigned COUNT_LSB   = 0;

    localparam int unsigned FIELD_WIDTH = LAYER_MSB - LAYER_LSB + 1;
    localparam int unsigned COUNT_WIDTH = COUNT_MSB - COUNT_LSB + 1;
    localparam int unsigned CFG_WIDTH   = 32;
    localparam int unsigned BLOCK_WIDTH = 16;

endpackage

// File: rtl/weight_loader.sv
// Configuration master for the neuron array: parses a host word stream of
// {header, bias, N weights} blocks and drives the shared weight/bias bus.
module weight_loader
    import npu_cfg_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned MAX_WEIGHTS = 1024,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   sValid_i,
    input  logic [DATA_WIDTH-1:0]  sData_i,
    input  logic                   sLast_i,
    output logic                   sReady_o,
    output logic                   weightValid_or,
    output logic [DATA_WIDTH-1:0]  weightValue_or,
    output logic                   biasValid_or,
    output logic [DATA_WIDTH-1:0]  biasValue_or,
    output logic [CFG_WIDTH-1:0]   configLayerNumber_or,
    output logic [CFG_WIDTH-1:0]   configNeuronNumber_or,
    output logic                   busy_o,
    output logic                   done_or,
    output logic                   error_or,
    output logic [BLOCK_WIDTH-1:0] blockCount_or
);

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  remaining;

    logic [FIELD_WIDTH-1:0]  hdr_layer;
    logic [FIELD_WIDTH-1:0]  hdr_neuron;
    logic [COUNT_WIDTH-1:0]  hdr_count;
    logic                    hdr_bad;
    logic                    accept;

    // Header field extraction and validity of the word currently offered
    always_comb begin
        hdr_layer  = sData_i[LAYER_MSB:LAYER_LSB];
        hdr_neuron = sData_i[NEURON_MSB:NEURON_LSB];
        hdr_count  = sData_i[COUNT_MSB:COUNT_LSB];
        hdr_bad    = (hdr_count == '0)
                  || (32'(hdr_count) > MAX_WEIGHTS)
                  || (32'(hdr_layer) >= NUM_LAYERS)
                  || sLast_i;
    end

    // Ready and busy are pure functions of state so the host sees them same-cycle
    always_comb begin
        sReady_o = (state == HDR) || (state == BIAS) || (state == WGT);
        busy_o   = sReady_o;
        accept   = sValid_i && sReady_o;
    end

    // Loader FSM with the remaining/block counters and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                 <= IDLE;
            remaining             <= '0;
            weightValid_or        <= 1'b0;
            weightValue_or        <= '0;
            biasValid_or          <= 1'b0;
            biasValue_or          <= '0;
            configLayerNumber_or  <= '0;
            configNeuronNumber_or <= '0;
            done_or               <= 1'b0;
            error_or              <= 1'b0;
            blockCount_or         <= '0;
        end else begin
            weightValid_or <= 1'b0;
            biasValid_or   <= 1'b0;
            done_or        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state         <= HDR;
                        blockCount_or <= '0;
                        error_or      <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state    <= ERR;
                            error_or <= 1'b1;
                        end else begin
                            configLayerNumber_or  <= CFG_WIDTH'(hdr_layer);
                            configNeuronNumber_or <= CFG_WIDTH'(hdr_neuron);
                            remaining             <= hdr_count;
                            state                 <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    if (accept) begin
                        biasValid_or <= 1'b1;
                        biasValue_or <= sData_i;
                        if (sLast_i) begin
                            state    <= ERR;
                            error_or <= 1'b1;
                        end else begin
                            state <= WGT;
                        end
                    end
                end
                WGT: begin
                    if (accept) begin
                        if (remaining == COUNT_WIDTH'(1)) begin
                            weightValid_or <= 1'b1;
                            weightValue_or <= sData_i;
                            blockCount_or  <= blockCount_or + BLOCK_WIDTH'(1);
                            remaining      <= '0;
                            if (sLast_i) begin
                                done_or <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= HDR;
                            end
                        end else if (sLast_i) begin
                            // Early end of stream: the truncating word is dropped
                            state    <= ERR;
                            error_or <= 1'b1;
                        end else begin
                            weightValid_or <= 1'b1;
                            weightValue_or <= sData_i;
                            remaining      <= remaining - COUNT_WIDTH'(1);
                        end
                    end
                end
                ERR: begin
                    error_or <= 1'b1;
                    if (start_i) begin
                        error_or <= 1'b0;
                        state    <= HDR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: table of header cases plus
// hand-written multi-cycle sequences, checked against a stream-parsing model.
module tb_weight_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        sValid_i;
    logic [31:0] sData_i;
    logic        sLast_i;
    logic        sReady_o;
    logic        weightValid_or;
    logic [31:0] weightValue_or;
    logic        biasValid_or;
    logic [31:0] biasValue_or;
    logic [31:0] configLayerNumber_or;
    logic [31:0] configNeuronNumber_or;
    logic        busy_o;
    logic        done_or;
    logic        error_or;
    logic [15:0] blockCount_or;

    weight_loader dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .sValid_i              (sValid_i),
        .sData_i               (sData_i),
        .sLast_i               (sLast_i),
        .sReady_o              (sReady_o),
        .weightValid_or        (weightValid_or),
        .weightValue_or        (weightValue_or),
        .biasValid_or          (biasValid_or),
        .biasValue_or          (biasValue_or),
        .configLayerNumber_or  (configLayerNumber_or),
        .configNeuronNumber_or (configNeuronNumber_or),
        .busy_o                (busy_o),
        .done_or               (done_or),
        .error_or              (error_or),
        .blockCount_or         (blockCount_or)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] val;
        logic [31:0] layer;
        logic [31:0] neuron;
    } strobe_t;

    typedef struct {
        logic [31:0] hdr;
        logic        hlast;
        logic        exp_err;
        logic [15:0] exp_blocks;
    } vec_t;

    strobe_t     got_b[$], got_w[$], exp_b[$], exp_w[$];
    logic [31:0] sw[$];
    logic        sl[$];
    int          got_done, exp_done, exp_blocks, exp_used;
    logic        exp_err;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: records every strobe together with the config numbers it saw
    always @(negedge clk_i) begin
        if (biasValid_or)
            got_b.push_back('{biasValue_or, configLayerNumber_or, configNeuronNumber_or});
        if (weightValid_or)
            got_w.push_back('{weightValue_or, configLayerNumber_or, configNeuronNumber_or});
        if (done_or) begin
            got_done++;
            check("busy_low_with_done", 32'(busy_o), 32'd0);
            check("weight_strobe_with_done", 32'(weightValid_or), 32'd1);
        end
    end

    // Reference: walk the stream block by block and list what the bus must show
    task automatic run_model();
        int p, idx, n;
        logic [31:0] lay, neu, cnt;
        bit stop;
        p = 0; n = sw.size(); stop = 0;
        exp_b.delete(); exp_w.delete();
        exp_done = 0; exp_blocks = 0; exp_err = 0; exp_used = n;
        while (!stop && p < n) begin
            lay = {24'd0, sw[p][31:24]};
            neu = {24'd0, sw[p][23:16]};
            cnt = {16'd0, sw[p][15:0]};
            if (cnt == 0 || cnt > 1024 || lay >= 4 || sl[p]) begin
                exp_err = 1; exp_used = p + 1; stop = 1;
            end else if (p + 1 >= n) begin
                stop = 1;
            end else begin
                exp_b.push_back('{sw[p+1], lay, neu});
                if (sl[p+1]) begin
                    exp_err = 1; exp_used = p + 2; stop = 1;
                end
                for (int k = 0; k < int'(cnt) && !stop; k++) begin
                    idx = p + 2 + k;
                    if (idx >= n) begin
                        stop = 1;
                    end else if (sl[idx] && k != int'(cnt) - 1) begin
                        exp_err = 1; exp_used = idx + 1; stop = 1;
                    end else begin
                        exp_w.push_back('{sw[idx], lay, neu});
                        if (k == int'(cnt) - 1) begin
                            exp_blocks++;
                            if (sl[idx]) begin
                                exp_done++; exp_used = idx + 1; stop = 1;
                            end
                        end
                    end
                end
                p = p + int'(cnt) + 2;
            end
        end
    endtask

    task automatic add_block(input logic [31:0] hdr, input bit final_last);
        int cnt;
        cnt = int'(hdr[15:0]);
        sw.push_back(hdr); sl.push_back(1'b0);
        sw.push_back($urandom); sl.push_back(1'b0);
        for (int k = 0; k < cnt; k++) begin
            sw.push_back($urandom);
            sl.push_back(final_last && (k == cnt - 1));
        end
    endtask

    // Offer words [from,to) with optional random gaps; called at posedge+1
    task automatic drive(input int from, input int to, input int gap_pct, output int cycles);
        int budget;
        bit acc, abort;
        cycles = 0; abort = 0;
        for (int i = from; i < to && !abort; i++) begin
            budget = 0;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct && budget < 8) begin
                sValid_i = 1'b0;
                @(posedge clk_i); #1;
                cycles++; budget++;
            end
            sValid_i = 1'b1; sData_i = sw[i]; sLast_i = sl[i];
            acc = 0; budget = 0;
            while (!acc && !abort) begin
                @(negedge clk_i);
                acc = sReady_o;
                @(posedge clk_i); #1;
                cycles++;
                if (!acc) begin
                    budget++;
                    if (budget > 20) begin
                        check("accept_timeout", 32'd0, 32'd1);
                        abort = 1;
                    end
                end
            end
        end
        sValid_i = 1'b0; sLast_i = 1'b0;
    endtask

    task automatic compare_all(input string name);
        check({name, "_bias_n"}, 32'(got_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            check({name, "_bias_val"}, got_b[i].val, exp_b[i].val);
            check({name, "_bias_layer"}, got_b[i].layer, exp_b[i].layer);
            check({name, "_bias_neuron"}, got_b[i].neuron, exp_b[i].neuron);
        end
        check({name, "_wgt_n"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            check({name, "_wgt_val"}, got_w[i].val, exp_w[i].val);
            check({name, "_wgt_layer"}, got_w[i].layer, exp_w[i].layer);
            check({name, "_wgt_neuron"}, got_w[i].neuron, exp_w[i].neuron);
        end
        check({name, "_done_n"}, 32'(got_done), 32'(exp_done));
        check({name, "_blocks"}, 32'(blockCount_or), 32'(exp_blocks));
        check({name, "_error"}, 32'(error_or), 32'(exp_err));
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_ready"}, 32'(sReady_o), 32'd0);
    endtask

    // Arm the loader, stream the model-accepted prefix, then compare
    task automatic run_case(input string name, input int gap_pct, input bit pre, output int cycles);
        got_b.delete(); got_w.delete(); got_done = 0;
        run_model();
        if (pre) begin
            sValid_i = 1'b1; sData_i = sw[0]; sLast_i = sl[0];
        end
        start_i = 1'b1;
        @(negedge clk_i);
        if (pre) check({name, "_no_ready_at_start"}, 32'(sReady_o), 32'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        drive(0, exp_used, gap_pct, cycles);
        repeat (3) @(posedge clk_i);
        #1;
        compare_all(name);
    endtask

    vec_t tbl[8];
    int   cyc;

    initial begin
        tbl[0] = '{32'h0102_0003, 1'b0, 1'b0, 16'd1};
        tbl[1] = '{32'h0000_0000, 1'b0, 1'b1, 16'd0};
        tbl[2] = '{32'h0400_0001, 1'b0, 1'b1, 16'd0};
        tbl[3] = '{32'h0309_0001, 1'b0, 1'b0, 16'd1};
        tbl[4] = '{32'h0000_0401, 1'b0, 1'b1, 16'd0};
        tbl[5] = '{32'h0111_0400, 1'b0, 1'b0, 16'd1};
        tbl[6] = '{32'hFF00_0001, 1'b0, 1'b1, 16'd0};
        tbl[7] = '{32'h0001_0001, 1'b1, 1'b1, 16'd0};

        rst_i = 1'b1; start_i = 1'b0; sValid_i = 1'b0; sData_i = '0; sLast_i = 1'b0;
        got_done = 0;
        #1;
        check("rst_wvalid", 32'(weightValid_or), 0);
        check("rst_wvalue", weightValue_or, 0);
        check("rst_bvalid", 32'(biasValid_or), 0);
        check("rst_bvalue", biasValue_or, 0);
        check("rst_layer", configLayerNumber_or, 0);
        check("rst_neuron", configNeuronNumber_or, 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_or), 0);
        check("rst_error", 32'(error_or), 0);
        check("rst_blocks", 32'(blockCount_or), 0);
        check("rst_ready", 32'(sReady_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Header table: legal blocks load fully, illegal headers land in ERR
        for (int r = 0; r < 8; r++) begin
            sw.delete(); sl.delete();
            if (tbl[r].exp_err) begin
                sw.push_back(tbl[r].hdr); sl.push_back(tbl[r].hlast);
            end else begin
                add_block(tbl[r].hdr, 1'b1);
            end
            run_case("tbl", 0, 1'b0, cyc);
            check("tbl_err_expected", 32'(error_or), 32'(tbl[r].exp_err));
            check("tbl_blocks_expected", 32'(blockCount_or), 32'(tbl[r].exp_blocks));
        end

        // Basic block with fixed values
        sw = '{32'h0102_0003, 32'h11, 32'hA, 32'hB, 32'hC};
        sl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_case("basic", 0, 1'b0, cyc);
        check("basic_bias", (got_b.size() > 0) ? got_b[0].val : 32'hDEAD, 32'h11);
        check("basic_w2", (got_w.size() > 2) ? got_w[2].val : 32'hDEAD, 32'hC);
        check("basic_layer", configLayerNumber_or, 32'd1);
        check("basic_neuron", configNeuronNumber_or, 32'd2);
        check("basic_done", 32'(got_done), 32'd1);

        // Back-to-back blocks with no bubble; also arm with valid already high
        sw.delete(); sl.delete();
        add_block(32'h0000_0002, 1'b0);
        add_block(32'h0307_0001, 1'b1);
        run_case("b2b", 0, 1'b1, cyc);
        check("b2b_cycles", 32'(cyc), 32'd7);
        check("b2b_blocks", 32'(blockCount_or), 32'd2);
        check("b2b_second_bias_layer", (got_b.size() > 1) ? got_b[1].layer : 32'hDEAD, 32'd3);

        // Error stays sticky with ready low until the next start
        sw = '{32'h0000_0000};
        sl = '{1'b0};
        run_case("cnt0", 0, 1'b0, cyc);
        repeat (5) @(posedge clk_i);
        #1;
        check("cnt0_sticky_err", 32'(error_or), 32'd1);
        check("cnt0_sticky_ready", 32'(sReady_o), 32'd0);
        sw = '{32'h0400_0002};
        sl = '{1'b0};
        run_case("layer4", 0, 1'b0, cyc);

        // Stream ends on the 2nd of 3 weights
        sw.delete(); sl.delete();
        add_block(32'h0201_0003, 1'b0);
        sl[3] = 1'b1;
        run_case("early_last", 0, 1'b0, cyc);
        check("early_last_wn", 32'(got_w.size()), 32'd1);

        // Random valid gaps over a 5-weight block, twice
        for (int t = 0; t < 2; t++) begin
            sw.delete(); sl.delete();
            add_block(32'h0106_0005, 1'b1);
            run_case("gaps", 40, 1'b0, cyc);
        end

        // Reset asserted mid-WGT after two weights were written
        sw.delete(); sl.delete();
        add_block(32'h0205_0005, 1'b1);
        run_case("pre_rst_clean", 0, 1'b0, cyc);
        got_b.delete(); got_w.delete(); got_done = 0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        drive(0, 4, 0, cyc);
        @(negedge clk_i);
        #1;
        sValid_i = 1'b1; sData_i = sw[4]; sLast_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("midrst_wvalid", 32'(weightValid_or), 0);
        check("midrst_wvalue", weightValue_or, 0);
        check("midrst_bvalue", biasValue_or, 0);
        check("midrst_layer", configLayerNumber_or, 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_ready", 32'(sReady_o), 0);
        check("midrst_blocks", 32'(blockCount_or), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0; sValid_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_wn", 32'(got_w.size()), 32'd2);
        check("midrst_w0", (got_w.size() > 0) ? got_w[0].val : 32'hDEAD, sw[2]);
        check("midrst_w1", (got_w.size() > 1) ? got_w[1].val : 32'hDEAD, sw[3]);
        check("midrst_idle_busy", 32'(busy_o), 0);
        run_case("post_rst", 0, 1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
